pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register, successor to the fixed-width enable-gated stage latches. Holds a WIDTH-bit payload between pipeline stages with a valid/ready handshake and a 2-entry skid buffer. Downstream back-pressure is absorbed without a combinational ready path from output to input. A synchronous flush squashes in-flight payloads on branch mispredict or exception.

---
 rtl/pipe_skid_reg.sv | 127 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready, out_valid and occupancy come straight from flops, so there is no
// combinational path from out_ready to in_ready and none from in_data to out_data.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH       = 132,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  // Next-state, entry updates and next values of the registered status outputs
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    occ_d       = OCC_W'(0);

    unique case (state_q)
      ST_EMPTY: begin
        if (in_valid) begin
          main_d  = in_data;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready && in_valid) begin
          main_d = in_data;
        end else if (out_ready) begin
          main_d  = RESET_VALUE;
          state_d = ST_EMPTY;
        end else if (in_valid) begin
          skid_d  = in_data;
          state_d = ST_SKID;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so in_data is never looked at
        if (out_ready) begin
          main_d  = skid_q;
          skid_d  = RESET_VALUE;
          state_d = ST_FULL;
        end
      end
      default: begin
        main_d  = RESET_VALUE;
        skid_d  = RESET_VALUE;
        state_d = ST_EMPTY;
      end
    endcase

    // Squash drops everything, including a payload offered this cycle
    if (flush) begin
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
      state_d = ST_EMPTY;
    end

    unique case (state_d)
      ST_FULL: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b1;
        occ_d       = OCC_W'(1);
      end
      ST_SKID: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        occ_d       = OCC_W'(2);
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        occ_d       = OCC_W'(0);
      end
    endcase
  end

  // State, entries and status flops; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= RESET_VALUE;
      skid_q      <= RESET_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= OCC_W'(0);
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: three instances (132-bit/zero reset,
// 32-bit/all-ones reset, 1-bit/zero reset) share one stimulus stream.
module tb_pipe_skid_reg;

  logic         clk;
  logic         reset;
  logic         flush;
  logic [131:0] in_data;
  logic         in_valid;
  logic         out_ready;

  logic         rdy0, rdy1, rdy2;
  logic         vld0, vld1, vld2;
  logic [1:0]   occ0, occ1, occ2;
  logic [131:0] dat0;
  logic [31:0]  dat1;
  logic [0:0]   dat2;

  int unsigned  n_cmp;
  int unsigned  n_err;
  logic [131:0] hold_v;

  pipe_skid_reg #(.WIDTH(132), .RESET_VALUE('0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .out_data(dat0), .out_valid(vld0), .out_ready(out_ready), .occupancy(occ0)
  );

  pipe_skid_reg #(.WIDTH(32), .RESET_VALUE(32'hFFFF_FFFF)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data[31:0]), .in_valid(in_valid), .in_ready(rdy1),
    .out_data(dat1), .out_valid(vld1), .out_ready(out_ready), .occupancy(occ1)
  );

  pipe_skid_reg #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data[0:0]), .in_valid(in_valid), .in_ready(rdy2),
    .out_data(dat2), .out_valid(vld2), .out_ready(out_ready), .occupancy(occ2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report a mismatch
  task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every instance against the expected stage contents
  task automatic expect_stage(input string tag, input logic exp_vld, input logic exp_rdy,
                              input logic [1:0] exp_occ, input logic [131:0] exp_dat);
    logic [31:0] e1;
    logic [0:0]  e2;
    e1 = exp_vld ? exp_dat[31:0] : 32'hFFFF_FFFF;
    e2 = exp_vld ? exp_dat[0:0]  : 1'b0;
    check({tag, ".vld0"}, 132'(vld0), 132'(exp_vld));
    check({tag, ".rdy0"}, 132'(rdy0), 132'(exp_rdy));
    check({tag, ".occ0"}, 132'(occ0), 132'(exp_occ));
    check({tag, ".dat0"}, dat0, exp_vld ? exp_dat : 132'd0);
    check({tag, ".hs1"},  132'({vld1, rdy1, occ1}), 132'({exp_vld, exp_rdy, exp_occ}));
    check({tag, ".dat1"}, 132'(dat1), 132'(e1));
    check({tag, ".hs2"},  132'({vld2, rdy2, occ2}), 132'({exp_vld, exp_rdy, exp_occ}));
    check({tag, ".dat2"}, 132'(dat2), 132'(e2));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset for two cycles, then idle
    tick();
    tick();
    expect_stage("reset", 1'b0, 1'b1, 2'd0, 132'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_stage("idle", 1'b0, 1'b1, 2'd0, 132'd0);
    end

    // Streaming: one in, one out per cycle
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = 132'(k);
      tick();
      expect_stage("stream", 1'b1, 1'b1, 2'd1, 132'(k));
    end
    in_valid = 1'b0;
    tick();
    expect_stage("drain", 1'b0, 1'b1, 2'd0, 132'd0);

    // Back-pressure into skid, then release: A, B, C in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 132'hA5;
    tick();
    expect_stage("skA", 1'b1, 1'b1, 2'd1, 132'hA5);
    in_data = 132'h5A;
    tick();
    expect_stage("skB", 1'b1, 1'b0, 2'd2, 132'hA5);
    in_data = 132'h33;
    tick();
    expect_stage("skC_held", 1'b1, 1'b0, 2'd2, 132'hA5);
    out_ready = 1'b1;
    tick();
    expect_stage("outB", 1'b1, 1'b1, 2'd1, 132'h5A);
    tick();
    expect_stage("outC", 1'b1, 1'b1, 2'd1, 132'h33);
    in_valid = 1'b0;
    tick();
    expect_stage("skdrain", 1'b0, 1'b1, 2'd0, 132'd0);

    // Stability under stall with MSB and LSB set
    hold_v    = {1'b1, 130'h2_DEAD_BEEF_0123_4567_89AB_CDEF, 1'b1};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = hold_v;
    tick();
    expect_stage("hold0", 1'b1, 1'b1, 2'd1, hold_v);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = {$urandom(), $urandom(), $urandom(), $urandom(), 4'($urandom())};
      tick();
      expect_stage("hold", 1'b1, 1'b1, 2'd1, hold_v);
      check("hold.b131", 132'(dat0[131]), 132'd1);
      check("hold.b0", 132'(dat0[0]), 132'd1);
    end

    // Flush in SKID with no input
    in_valid = 1'b1;
    in_data  = 132'h5A;
    tick();
    expect_stage("fl_fill", 1'b1, 1'b0, 2'd2, hold_v);
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    expect_stage("flush", 1'b0, 1'b1, 2'd0, 132'd0);
    flush = 1'b0;

    // Flush in SKID with a simultaneous valid input
    in_valid = 1'b1;
    in_data  = 132'h11;
    tick();
    in_data = 132'h22;
    tick();
    expect_stage("fl2_fill", 1'b1, 1'b0, 2'd2, 132'h11);
    flush   = 1'b1;
    in_data = 132'h77;
    tick();
    expect_stage("flush_in", 1'b0, 1'b1, 2'd0, 132'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_stage("flush_gone", 1'b0, 1'b1, 2'd0, 132'd0);

    // Reset and flush together in FULL with a valid input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 132'h3C;
    tick();
    expect_stage("pr_fill", 1'b1, 1'b1, 2'd1, 132'h3C);
    reset   = 1'b1;
    flush   = 1'b1;
    in_data = 132'hC3;
    tick();
    expect_stage("rst_fl", 1'b0, 1'b1, 2'd0, 132'd0);
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_stage("rst_fl_idle", 1'b0, 1'b1, 2'd0, 132'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
